// File: rtl/bus_arbiter16_pkg.sv
// Shared constants, FSM state type and grant decode helper for the 16-way
// round-robin datapath arbiter.
package bus_arbiter16_pkg;

  localparam int unsigned ARB_N     = 16;
  localparam int unsigned ARB_SEL_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

  function automatic logic [ARB_N-1:0] arb_onehot(input logic [ARB_SEL_W-1:0] idx);
    logic [ARB_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter16_if.sv
// Requester-side bus of the arbiter: request vector in, grant/select/status out.
interface bus_arbiter16_if;
  import bus_arbiter16_pkg::*;

  logic [ARB_N-1:0]     req;
  logic [ARB_N-1:0]     grant;
  logic [ARB_SEL_W-1:0] sel;
  logic                 busy;
  logic                 handoff;

  modport master (output req, input grant, input sel, input busy, input handoff);
  modport slave  (input req, output grant, output sel, output busy, output handoff);

endinterface

// File: rtl/bus_arbiter16_rr_pri_enc16.sv
// Rotating priority encoder: first set bit of req searching upward from last+1,
// wrapping 15->0, so index 'last' itself has the lowest priority.
module rr_pri_enc16
  import bus_arbiter16_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_SEL_W-1:0] last,
  output logic                 found,
  output logic [ARB_SEL_W-1:0] idx
);

  logic [ARB_SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= ARB_N; k++) begin
      // k == ARB_N truncates to 0, i.e. 'last' is tried last
      cand = last + ARB_SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter16.sv
// Round-robin arbiter for a shared 32-bit 16:1 mux with bounded tenure.
// grant/busy are decoded from the registered owner; sel holds the last owner.
module bus_arbiter16
  import bus_arbiter16_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  bus_arbiter16_if.slave bus
);

  if (CNT_W < 32 && (32'd1 << CNT_W) <= MAX_HOLD) begin : g_cnt_w_check
    $error("bus_arbiter16: CNT_W too narrow for MAX_HOLD");
  end

  localparam int unsigned HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_LAST_I[CNT_W-1:0];

  arb_state_e           state_q, state_d;
  logic [ARB_SEL_W-1:0] sel_q, sel_d;
  logic [ARB_SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                 handoff_q, handoff_d;

  logic [ARB_SEL_W-1:0] srch_ptr;
  logic                 found;
  logic [ARB_SEL_W-1:0] win;
  logic                 timeout;
  logic                 release_now;

  // While owning, search from the owner so it ends up with lowest priority
  assign srch_ptr = (state_q == ARB_OWN) ? sel_q : last_q;

  rr_pri_enc16 u_enc (
    .req   (bus.req),
    .last  (srch_ptr),
    .found (found),
    .idx   (win)
  );

  assign timeout     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign release_now = !bus.req[sel_q] || timeout;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    handoff_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d    = ARB_OWN;
          sel_d      = win;
          last_d     = win;
          hold_cnt_d = '0;
          handoff_d  = 1'b1;
        end
      end
      ARB_OWN: begin
        if (!release_now) begin
          if (hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end
        end else if (found) begin
          sel_d      = win;
          last_d     = win;
          hold_cnt_d = '0;
          handoff_d  = 1'b1;
        end else begin
          state_d    = ARB_IDLE;
          hold_cnt_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      sel_q      <= '0;
      last_q     <= 4'd15;
      hold_cnt_q <= '0;
      handoff_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      handoff_q  <= handoff_d;
    end
  end

  assign bus.grant   = (state_q == ARB_OWN) ? arb_onehot(sel_q) : '0;
  assign bus.busy    = (state_q == ARB_OWN);
  assign bus.sel     = sel_q;
  assign bus.handoff = handoff_q;

endmodule

// File: tb/tb_bus_arbiter16.sv
// Scoreboard bench for bus_arbiter16 (MAX_HOLD=4): directed scenarios followed
// by random request traffic, checked against a behavioural round-robin model.
module tb_bus_arbiter16;
  import bus_arbiter16_pkg::*;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bus_arbiter16_if bus ();

  bus_arbiter16 #(.MAX_HOLD(MH), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        busy;
    logic        handoff;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Model: owner index (-1 idle), last winner, visible sel, cycles granted so far
  int   m_owner, m_last, m_sel, m_tenure;
  bit   m_handoff;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int rr_pick(input logic [15:0] r, input int ptr);
    for (int k = 1; k <= 16; k++) begin
      int j;
      j = (ptr + k) % 16;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [15:0] g);
    for (int i = 0; i < 16; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_last    = 15;
    m_sel     = 0;
    m_tenure  = 0;
    m_handoff = 1'b0;
  endtask

  task automatic grant_to(input int w);
    m_owner   = w;
    m_last    = w;
    m_sel     = w;
    m_tenure  = 1;
    m_handoff = 1'b1;
  endtask

  task automatic model_step(input logic [15:0] r);
    exp_t e;
    int   w;
    if (m_owner < 0) begin
      w = rr_pick(r, m_last);
      if (w >= 0) grant_to(w);
      else m_handoff = 1'b0;
    end else if (r[m_owner] && m_tenure < MH) begin
      m_tenure++;
      m_handoff = 1'b0;
    end else begin
      w = rr_pick(r, m_owner);
      if (w >= 0) grant_to(w);
      else begin
        m_owner   = -1;
        m_handoff = 1'b0;
      end
    end
    e.grant   = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
    e.sel     = 4'(m_sel);
    e.busy    = (m_owner >= 0);
    e.handoff = m_handoff;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] r);
    @(negedge clk);
    bus.req = r;
    model_step(r);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_grant"},   32'(bus.grant),   32'h0);
    check({tag, "_sel"},     32'(bus.sel),     32'h0);
    check({tag, "_busy"},    32'(bus.busy),    32'h0);
    check({tag, "_handoff"}, 32'(bus.handoff), 32'h0);
  endtask

  // Monitor: compare every post-edge output against the queued expectation
  int run = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant",   32'(bus.grant),   32'(e.grant));
        check("sel",     32'(bus.sel),     32'(e.sel));
        check("busy",    32'(bus.busy),    32'(e.busy));
        check("handoff", 32'(bus.handoff), 32'(e.handoff));
        check("onehot", 32'(bus.grant & (bus.grant - 16'd1)), 32'h0);
        check("busy_eq_or", 32'(bus.busy), 32'(|bus.grant));
        if (bus.busy) check("sel_idx", 32'(bus.sel), 32'(idx_of(bus.grant)));
        if (!bus.busy) run = 0;
        else if (bus.handoff) run = 1;
        else run++;
        check("tenure_le_max", 32'(run > MH), 32'h0);
      end
    end
  end

  initial begin
    logic [15:0] r;
    reset_n = 1'b0;
    bus.req = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 check_cleared("reset");

    // First grant from reset goes to index 0
    drive(16'h0001);
    drive(16'h0001);
    drive(16'h0000);
    drive(16'h0000);

    // Two contenders alternate every MH cycles without idle bubbles
    repeat (16) drive(16'h8001);
    repeat (2) drive(16'h0000);

    // Sole requester is re-granted after each timeout
    repeat (10) drive(16'h0020);
    repeat (2) drive(16'h0000);

    // Owner 3 drops with 2 and 9 waiting: 9 first, then 2
    drive(16'h0008);
    drive(16'h020C);
    repeat (6) drive(16'h0204);
    repeat (2) drive(16'h0000);

    // Owner 7 drops alone: idle, sel stays 7
    drive(16'h0080);
    drive(16'h0080);
    repeat (3) drive(16'h0000);

    // Async reset mid-tenure of owner 12
    drive(16'h1000);
    drive(16'h1000);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_cleared("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    bus.req = 16'hFFFF;
    model_reset();
    model_step(16'hFFFF);
    repeat (10) drive(16'hFFFF);
    repeat (2) drive(16'h0000);

    // Random level-style requests: bits toggle sparsely, occasional full drop
    r = '0;
    repeat (400) begin
      r = r ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      if ($urandom_range(0, 19) == 0) r = '0;
      drive(r);
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
